// File: rtl/lc3_mem_access_ctrl.sv
// rtl/lc3_mem_access_ctrl.sv - LC-3 LD/LDI/LDR/ST/STI/STR/LEA memory access sequencer; LC3_ACV_EN enables access-control checking
module lc3_mem_access_ctrl (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   input  logic [2:0]  i_op,
   input  logic [15:0] i_ir,
   input  logic [15:0] i_sr_data,
   output logic        o_addr1mux,
   output logic [1:0]  o_addr2mux,
   input  logic [15:0] i_addermux_out,
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic [15:0] o_mem_addr,
   output logic [15:0] o_mem_wdata,
   input  logic        i_mem_ready,
   input  logic [15:0] i_mem_rdata,
   input  logic        i_priv,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_wb_en,
   output logic [15:0] o_wb_data,
   output logic        o_acv
);

   localparam logic [2:0] OP_LD  = 3'b000;
   localparam logic [2:0] OP_LDI = 3'b001;
   localparam logic [2:0] OP_LDR = 3'b010;
   localparam logic [2:0] OP_ST  = 3'b011;
   localparam logic [2:0] OP_STI = 3'b100;
   localparam logic [2:0] OP_STR = 3'b101;
   localparam logic [2:0] OP_LEA = 3'b110;
   localparam logic [2:0] OP_RSV = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_EA   = 3'd1,
      S_IND  = 3'd2,
      S_ACC  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t      state_q;
   state_t      state_d;

   logic [2:0]  op_q;
   logic [15:0] ir_q;
   logic [15:0] sr_q;
   logic [15:0] mar_q;
   logic [15:0] wb_q;

   logic        start_ok;
   logic        is_store;
   logic        is_indirect;
   logic        is_lea;
   logic        is_base_reg;
   logic        is_wb_op;
   logic        viol;

   // The offset fields reach the adder outside this block; the captured IR is
   // held only so the instruction stays stable for the whole access.
   logic        unused_ir;
   assign unused_ir = ^ir_q;

   assign start_ok    = i_start && (i_op != OP_RSV);
   assign is_store    = (op_q == OP_ST) || (op_q == OP_STI) || (op_q == OP_STR);
   assign is_indirect = (op_q == OP_LDI) || (op_q == OP_STI);
   assign is_lea      = (op_q == OP_LEA);
   assign is_base_reg = (op_q == OP_LDR) || (op_q == OP_STR);
   assign is_wb_op    = (op_q == OP_LD) || (op_q == OP_LDI) ||
                        (op_q == OP_LDR) || (op_q == OP_LEA);

   assign o_mem_addr  = mar_q;
   assign o_mem_wdata = sr_q;
   assign o_wb_data   = wb_q;

`ifdef LC3_ACV_EN
   // System space (x0000-x2FFF) and device registers (xFE00-xFFFF) are
   // off-limits to user-mode accesses.
   function automatic logic prot_addr(input logic [15:0] a);
      return (a < 16'h3000) || (a >= 16'hFE00);
   endfunction

   // Flag a violation on the EA result (LEA never touches memory) or on the
   // pointer returned by the indirect read, in user mode only.
   always_comb begin
      viol = 1'b0;
      if (i_priv) begin
         if ((state_q == S_EA) && !is_lea) begin
            viol = prot_addr(i_addermux_out);
         end else if ((state_q == S_IND) && i_mem_ready) begin
            viol = prot_addr(i_mem_rdata);
         end
      end
   end
`else
   logic unused_priv;
   assign unused_priv = i_priv;
   assign viol        = 1'b0;
`endif

   // Next-state logic for the access sequence.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start_ok) begin
               state_d = S_EA;
            end
         end
         S_EA: begin
            if (is_lea || viol) begin
               state_d = S_DONE;
            end else if (is_indirect) begin
               state_d = S_IND;
            end else begin
               state_d = S_ACC;
            end
         end
         S_IND: begin
            if (i_mem_ready) begin
               state_d = viol ? S_DONE : S_ACC;
            end
         end
         S_ACC: begin
            if (i_mem_ready) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Adder operand selects; only meaningful while the EA is being formed.
   always_comb begin
      o_addr1mux = 1'b0;
      o_addr2mux = 2'b00;
      if (state_q == S_EA) begin
         if (is_base_reg) begin
            o_addr1mux = 1'b1;
            o_addr2mux = 2'b01;
         end else begin
            o_addr1mux = 1'b0;
            o_addr2mux = 2'b10;
         end
      end
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Request capture, MAR and write-back value.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         op_q  <= 3'b000;
         ir_q  <= 16'h0000;
         sr_q  <= 16'h0000;
         mar_q <= 16'h0000;
         wb_q  <= 16'h0000;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_ok) begin
                  op_q <= i_op;
                  ir_q <= i_ir;
                  sr_q <= i_sr_data;
               end
            end
            S_EA: begin
               mar_q <= i_addermux_out;
               if (is_lea) begin
                  wb_q <= i_addermux_out;
               end
            end
            S_IND: begin
               if (i_mem_ready) begin
                  mar_q <= i_mem_rdata;
               end
            end
            S_ACC: begin
               if (i_mem_ready && !is_store) begin
                  wb_q <= i_mem_rdata;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Status and memory strobes are registered from the next state so they line
   // up exactly with the state they describe.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
         o_mem_req <= 1'b0;
         o_mem_we  <= 1'b0;
         o_wb_en   <= 1'b0;
         o_acv     <= 1'b0;
      end else begin
         o_busy    <= (state_d != S_IDLE);
         o_done    <= (state_d == S_DONE);
         o_mem_req <= (state_d == S_IND) || (state_d == S_ACC);
         o_mem_we  <= (state_d == S_ACC) && is_store;
         o_wb_en   <= (state_d == S_DONE) && is_wb_op && !viol;
         o_acv     <= (state_d == S_DONE) && viol;
      end
   end

endmodule

// File: tb/tb_lc3_mem_access_ctrl.sv
// tb/tb_lc3_mem_access_ctrl.sv - directed table-driven bench for lc3_mem_access_ctrl
module tb_lc3_mem_access_ctrl;

   localparam logic [2:0] OP_LD  = 3'b000;
   localparam logic [2:0] OP_LDI = 3'b001;
   localparam logic [2:0] OP_LDR = 3'b010;
   localparam logic [2:0] OP_ST  = 3'b011;
   localparam logic [2:0] OP_STI = 3'b100;
   localparam logic [2:0] OP_STR = 3'b101;
   localparam logic [2:0] OP_LEA = 3'b110;
   localparam logic [2:0] OP_RSV = 3'b111;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_start;
   logic [2:0]  i_op;
   logic [15:0] i_ir;
   logic [15:0] i_sr_data;
   logic        o_addr1mux;
   logic [1:0]  o_addr2mux;
   logic [15:0] i_addermux_out;
   logic        o_mem_req;
   logic        o_mem_we;
   logic [15:0] o_mem_addr;
   logic [15:0] o_mem_wdata;
   logic        i_mem_ready;
   logic [15:0] i_mem_rdata;
   logic        i_priv;
   logic        o_busy;
   logic        o_done;
   logic        o_wb_en;
   logic [15:0] o_wb_data;
   logic        o_acv;

   lc3_mem_access_ctrl dut (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_start        (i_start),
      .i_op           (i_op),
      .i_ir           (i_ir),
      .i_sr_data      (i_sr_data),
      .o_addr1mux     (o_addr1mux),
      .o_addr2mux     (o_addr2mux),
      .i_addermux_out (i_addermux_out),
      .o_mem_req      (o_mem_req),
      .o_mem_we       (o_mem_we),
      .o_mem_addr     (o_mem_addr),
      .o_mem_wdata    (o_mem_wdata),
      .i_mem_ready    (i_mem_ready),
      .i_mem_rdata    (i_mem_rdata),
      .i_priv         (i_priv),
      .o_busy         (o_busy),
      .o_done         (o_done),
      .o_wb_en        (o_wb_en),
      .o_wb_data      (o_wb_data),
      .o_acv          (o_acv)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [2:0]  op;
      logic        priv;
      logic [15:0] adder;
      logic [15:0] ptr;
      logic [15:0] data;
      logic [15:0] sr;
      int          waits;
      logic        a1m;
      logic [1:0]  a2m;
      int          cyc;
      int          nacc;
      logic [15:0] a0;
      logic        we0;
      logic [15:0] a1;
      logic        we1;
      logic        wb_en;
      logic [15:0] wb_data;
      logic        acv;
   } vec_t;

   localparam int NVEC = 13;
   vec_t vecs[NVEC];

   int n_checks = 0;
   int n_fail   = 0;

   function automatic vec_t mk(
      input logic [2:0] op, input logic priv, input logic [15:0] adder,
      input logic [15:0] ptr, input logic [15:0] data, input logic [15:0] sr,
      input int waits, input logic a1m, input logic [1:0] a2m, input int cyc,
      input int nacc, input logic [15:0] a0, input logic we0, input logic [15:0] a1,
      input logic we1, input logic wb_en, input logic [15:0] wb_data, input logic acv);
      vec_t v;
      v.op = op; v.priv = priv; v.adder = adder; v.ptr = ptr; v.data = data;
      v.sr = sr; v.waits = waits; v.a1m = a1m; v.a2m = a2m; v.cyc = cyc;
      v.nacc = nacc; v.a0 = a0; v.we0 = we0; v.a1 = a1; v.we1 = we1;
      v.wb_en = wb_en; v.wb_data = wb_data; v.acv = acv;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v, input bit noise);
      int          done_cyc;
      int          wcnt;
      int          nacc;
      logic [15:0] acc_a[4];
      logic        acc_we[4];
      logic [15:0] acc_wd[4];
      logic        wb_en;
      logic [15:0] wb_data;
      logic        acv;
      string       tag;
      done_cyc = 0; wcnt = 0; nacc = 0;
      wb_en = 1'b0; wb_data = 16'h0000; acv = 1'b0;
      for (int k = 0; k < 4; k++) begin
         acc_a[k] = 16'h0; acc_we[k] = 1'b0; acc_wd[k] = 16'h0;
      end
      tag = $sformatf("v%0d%s", idx, noise ? "n" : "");
      i_priv         = v.priv;
      i_addermux_out = v.adder;
      i_sr_data      = v.sr;
      i_ir           = 16'hA5A5;
      i_op           = v.op;
      i_start        = 1'b1;
      @(negedge i_clk);
      i_start = noise;
      if (noise) i_op = OP_ST;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         i_mem_ready = 1'b0;
         if (cyc == 1) begin
            check({tag, " ea_addr1mux"}, 32'(o_addr1mux), 32'(v.a1m));
            check({tag, " ea_addr2mux"}, 32'(o_addr2mux), 32'(v.a2m));
            check({tag, " ea_busy"}, 32'(o_busy), 32'd1);
         end
         if (cyc == 2) begin
            i_start = 1'b0;
            check({tag, " post_ea_muxes"}, {29'd0, o_addr1mux, o_addr2mux}, 32'd0);
         end
         if (o_done) begin
            done_cyc = cyc;
            wb_en    = o_wb_en;
            wb_data  = o_wb_data;
            acv      = o_acv;
            break;
         end
         if (o_mem_req) begin
            wcnt++;
            if (wcnt > v.waits) begin
               i_mem_ready = 1'b1;
               i_mem_rdata = (nacc == 0 && (v.op == OP_LDI || v.op == OP_STI)) ? v.ptr : v.data;
               if (nacc < 4) begin
                  acc_a[nacc]  = o_mem_addr;
                  acc_we[nacc] = o_mem_we;
                  acc_wd[nacc] = o_mem_wdata;
               end
               nacc++;
               wcnt = 0;
            end
         end
         @(negedge i_clk);
      end
      i_mem_ready = 1'b0;
      i_start     = 1'b0;
      check({tag, " done_cycle"}, 32'(done_cyc), 32'(v.cyc));
      check({tag, " num_access"}, 32'(nacc), 32'(v.nacc));
      if (v.nacc >= 1) begin
         check({tag, " acc0_addr"}, 32'(acc_a[0]), 32'(v.a0));
         check({tag, " acc0_we"}, 32'(acc_we[0]), 32'(v.we0));
         if (v.we0) check({tag, " acc0_wdata"}, 32'(acc_wd[0]), 32'(v.sr));
      end
      if (v.nacc >= 2) begin
         check({tag, " acc1_addr"}, 32'(acc_a[1]), 32'(v.a1));
         check({tag, " acc1_we"}, 32'(acc_we[1]), 32'(v.we1));
         if (v.we1) check({tag, " acc1_wdata"}, 32'(acc_wd[1]), 32'(v.sr));
      end
      check({tag, " wb_en"}, 32'(wb_en), 32'(v.wb_en));
      if (v.wb_en) check({tag, " wb_data"}, 32'(wb_data), 32'(v.wb_data));
      check({tag, " acv"}, 32'(acv), 32'(v.acv));
      @(negedge i_clk);
      check({tag, " idle_after"}, {30'd0, o_busy, o_done}, 32'd0);
      if (noise) begin
         for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            check({tag, " quiet_after"}, {30'd0, o_mem_req, o_done}, 32'd0);
         end
      end
   endtask

   initial begin
      int seen_done;
      vecs[0]  = mk(OP_LD,  0, 16'h3005, 16'h0000, 16'hBEEF, 16'h0000, 0, 0, 2'b10, 3, 1, 16'h3005, 0, 16'h0000, 0, 1, 16'hBEEF, 0);
      vecs[1]  = mk(OP_STI, 0, 16'h4000, 16'h5000, 16'h0000, 16'h1234, 2, 0, 2'b10, 8, 2, 16'h4000, 0, 16'h5000, 1, 0, 16'h0000, 0);
      vecs[2]  = mk(OP_LEA, 0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 0, 0, 2'b10, 2, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'hFFFF, 0);
      vecs[3]  = mk(OP_LDR, 0, 16'h3100, 16'h0000, 16'h0042, 16'h0000, 1, 1, 2'b01, 4, 1, 16'h3100, 0, 16'h0000, 0, 1, 16'h0042, 0);
      vecs[4]  = mk(OP_STR, 0, 16'h4010, 16'h0000, 16'h0000, 16'hABCD, 0, 1, 2'b01, 3, 1, 16'h4010, 1, 16'h0000, 0, 0, 16'h0000, 0);
      vecs[5]  = mk(OP_LDI, 0, 16'h3200, 16'h3300, 16'h7777, 16'h0000, 0, 0, 2'b10, 4, 2, 16'h3200, 0, 16'h3300, 0, 1, 16'h7777, 0);
      vecs[6]  = mk(OP_ST,  0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0001, 0, 0, 2'b10, 3, 1, 16'hFFFF, 1, 16'h0000, 0, 0, 16'h0000, 0);
`ifdef LC3_ACV_EN
      vecs[7]  = mk(OP_LD,  1, 16'h2FFF, 16'h0000, 16'h1111, 16'h0000, 0, 0, 2'b10, 2, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 1);
      vecs[8]  = mk(OP_LDI, 1, 16'h3000, 16'hFE00, 16'h2222, 16'h0000, 0, 0, 2'b10, 3, 1, 16'h3000, 0, 16'h0000, 0, 0, 16'h0000, 1);
`else
      vecs[7]  = mk(OP_LD,  1, 16'h2FFF, 16'h0000, 16'h1111, 16'h0000, 0, 0, 2'b10, 3, 1, 16'h2FFF, 0, 16'h0000, 0, 1, 16'h1111, 0);
      vecs[8]  = mk(OP_LDI, 1, 16'h3000, 16'hFE00, 16'h2222, 16'h0000, 0, 0, 2'b10, 4, 2, 16'h3000, 0, 16'hFE00, 0, 1, 16'h2222, 0);
`endif
      vecs[9]  = mk(OP_LD,  0, 16'h2FFF, 16'h0000, 16'h3333, 16'h0000, 0, 0, 2'b10, 3, 1, 16'h2FFF, 0, 16'h0000, 0, 1, 16'h3333, 0);
      vecs[10] = mk(OP_LEA, 1, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 0, 0, 2'b10, 2, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0100, 0);
      vecs[11] = mk(OP_STR, 1, 16'h3000, 16'h0000, 16'h0000, 16'h5A5A, 3, 1, 2'b01, 6, 1, 16'h3000, 1, 16'h0000, 0, 0, 16'h0000, 0);
      vecs[12] = mk(OP_LD,  1, 16'hFDFF, 16'h0000, 16'h0F0F, 16'h0000, 0, 0, 2'b10, 3, 1, 16'hFDFF, 0, 16'h0000, 0, 1, 16'h0F0F, 0);

      i_rst_n = 1'b0; i_start = 1'b0; i_op = OP_LD; i_ir = 16'h0; i_sr_data = 16'h0;
      i_addermux_out = 16'h0; i_mem_ready = 1'b0; i_mem_rdata = 16'h0; i_priv = 1'b0;
      repeat (2) @(negedge i_clk);
      check("reset_status", {27'd0, o_busy, o_done, o_mem_req, o_mem_we, o_acv}, 32'd0);
      check("reset_wb", {15'd0, o_wb_en, o_wb_data}, 32'd0);
      check("reset_addr", {o_mem_addr, o_mem_wdata}, 32'd0);
      check("reset_muxes", {29'd0, o_addr1mux, o_addr2mux}, 32'd0);
      i_rst_n = 1'b1;
      @(negedge i_clk);

      for (int i = 0; i < NVEC; i++) begin
         run_vec(i, vecs[i], 1'b0);
      end

      // Reserved op in IDLE is ignored.
      i_op = OP_RSV; i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      check("rsv_op_busy", {30'd0, o_busy, o_mem_req}, 32'd0);
      @(negedge i_clk);
      check("rsv_op_done", {30'd0, o_busy, o_done}, 32'd0);

      // Start held during a busy LD is ignored.
      run_vec(0, vecs[0], 1'b1);

      // Asynchronous reset while the data access is pending.
      i_priv = 1'b0; i_op = OP_LD; i_addermux_out = 16'h3005; i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      for (int k = 0; k < 10 && !o_mem_req; k++) @(negedge i_clk);
      check("rst_req_seen", 32'(o_mem_req), 32'd1);
      #2 i_rst_n = 1'b0;
      #1 check("rst_async_clear", {29'd0, o_mem_req, o_busy, o_done}, 32'd0);
      seen_done = 0;
      @(negedge i_clk);
      i_rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge i_clk);
         if (o_done || o_wb_en) seen_done++;
      end
      check("rst_no_done", 32'(seen_done), 32'd0);
      run_vec(5, vecs[5], 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lc3_mem_access_ctrl.md
LC3_MEM_ACCESS_CTRL -- requirements
Module: lc3_mem_access_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports listed below (clock and reset first).
REQ-002 i_clk  input  1  rising-edge clock.
REQ-003 i_rst_n  input  1  asynchronous active-low reset.
REQ-004 i_start  input  1  request pulse; sampled only in IDLE.
REQ-005 i_op  input  3  000 LD, 001 LDI, 010 LDR, 011 ST, 100 STI, 101 STR, 110 LEA, 111 reserved.
REQ-006 i_ir  input  16  instruction word; captured on accepted start.
REQ-007 i_sr_data  input  16  store data; captured on accepted start.
REQ-008 o_addr1mux  output  1  adder base select: 0 = PC, 1 = SR1.
REQ-009 o_addr2mux  output  2  adder offset select: 00 = zero, 01 = IR[5:0], 10 = IR[8:0], 11 = IR[10:0].
REQ-010 i_addermux_out  input  16  effective-address adder result.
REQ-011 o_mem_req, o_mem_we  output  1 each  memory request and write enable.
REQ-012 o_mem_addr, o_mem_wdata  output  16 each  memory address (MAR) and write data.
REQ-013 i_mem_ready  input  1  memory completes the access in the cycle it is high while o_mem_req is high.
REQ-014 i_mem_rdata  input  16  read data, valid with i_mem_ready.
REQ-015 i_priv  input  1  1 = user mode.
REQ-016 o_busy  output  1  high in every state except IDLE.
REQ-017 o_done  output  1  one-cycle completion pulse.
REQ-018 o_wb_en, o_wb_data  output  1 / 16  register write-back strobe and value.
REQ-019 o_acv  output  1  access-control violation flag, valid with o_done.

Function
REQ-020 FSM states SHALL be IDLE, EA, IND, ACC and DONE.
- IDLE: if i_start=1 and i_op≠111, capture i_op, i_ir and i_sr_data, then go to EA.
- If i_op=111 or the block is not in IDLE, i_start SHALL be ignored.
REQ-021 In EA, the mux selects SHALL be driven from the captured op:
- LD, LDI, ST, STI, LEA: addr1mux = 0, addr2mux = 10.
- LDR, STR: addr1mux = 1, addr2mux = 01.
- In all other states: addr1mux = 0, addr2mux = 00.
REQ-022 EA SHALL last exactly one cycle and latch i_addermux_out into MAR (16-bit, carry discarded).
- Next state: LEA goes to DONE; LDI and STI go to IND; all other ops go to ACC.
REQ-023 IND SHALL assert req=1, we=0 and addr=MAR, holding them until i_mem_ready.
- On ready: MAR <= i_mem_rdata, then go to ACC.
REQ-024 ACC SHALL assert req=1, we=1 for ST/STI/STR (0 otherwise), addr=MAR and wdata=captured store data, holding them until i_mem_ready.
- On ready, loads latch i_mem_rdata into the write-back register.
- Then go to DONE.
REQ-025 DONE SHALL last one cycle, with o_done=1, then go to IDLE.
- o_wb_en=1 for LD/LDI/LDR/LEA without violation; o_wb_data = load data, or MAR for LEA.
REQ-026 With zero wait states, o_done SHALL assert 2 cycles after the accepting edge for LEA, 3 for LD/LDR/ST/STR and 4 for LDI/STI; each wait cycle adds one cycle.
REQ-027 o_mem_req SHALL be low in IDLE, EA and DONE; outputs other than the mux selects SHALL be registered.
REQ-028 i_mem_ready outside IND/ACC SHALL be ignored.

Reset
REQ-029 On i_rst_n low, the FSM SHALL enter IDLE immediately, and all registers and outputs SHALL be 0 (o_busy=0, o_mem_req=0, o_done=0, o_acv=0).
REQ-030 Reset mid-access SHALL abort the operation with no o_done and no write-back; after release the block SHALL accept a new start.

Configuration
REQ-031 Macro LC3_ACV_EN SHALL enable access-control checking; the check applies only when i_priv=1.
- Trigger: an address in x0000–x2FFF or xFE00–xFFFF.
- Checked points: the MAR latched at end of EA (except LEA), and the pointer read in IND.
- On violation, the block SHALL skip remaining memory accesses, go to DONE with o_acv=1 and o_wb_en=0, and issue no write.
REQ-032 Without LC3_ACV_EN, o_acv SHALL be tied 0 and no check SHALL occur; the port list SHALL be identical in both builds.

Verification
REQ-033 LD, adder returns x3005, ready same cycle, rdata xBEEF -> one read at x3005, o_done on cycle 3 with o_wb_en=1 and o_wb_data=xBEEF.
REQ-034 STI, adder x4000, pointer read returns x5000, i_sr_data x1234, ready delayed 2 cycles per access -> read x4000 then write x5000/x1234, o_done on cycle 8, o_wb_en=0.
REQ-035 LEA, adder xFFFF -> no memory request, o_done on cycle 2, o_wb_data=xFFFF; LDR in EA shows addr1mux=1, addr2mux=01.
REQ-036 i_start during a busy LD and i_start with op 111 in IDLE -> both ignored, no extra memory access, single o_done.
REQ-037 i_rst_n pulsed low while o_mem_req=1 in ACC -> o_mem_req=0 and o_busy=0 asynchronously, no o_done.
REQ-038 With LC3_ACV_EN and i_priv=1, LD with adder x2FFF -> no memory request, o_done with o_acv=1, o_wb_en=0; same stimulus with i_priv=0 -> normal read.
